// File: rtl/wozmon_rom_arbiter.sv
// wozmon_rom_arbiter
//   Shares the single-port Woz Mon ROM (synchronous read, one-cycle latency)
//   between the 6502 bus interface (CPU port) and the debug/monitor-dump
//   engine (DBG port). At most one read is granted per cycle, and the
//   response is tagged so the returning byte's valid pulse reaches the
//   requester that issued it. The CPU has priority.
//
//   Build option: define ROM_ARB_STARVE_EN to add a starvation guard. DBG is
//   then forced through after STARVE_LIMIT consecutive denied cycles.
//   Without the macro, priority is strict and no counter logic exists.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 synchronous active-high reset
//   cpu_req, cpu_addr   CPU read request and address (held until granted)
//   cpu_gnt             combinational grant for this cycle
//   cpu_valid           one-cycle pulse, the cycle after cpu_gnt
//   cpu_data            ROM byte, meaningful while cpu_valid is high
//   dbg_*               same as the CPU port, for the debug engine
//   rom_addr            address to the ROM wrapper
//   rom_dout            registered ROM output
module wozmon_rom_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_gnt,
  output logic                  cpu_valid,
  output logic [DATA_WIDTH-1:0] cpu_data,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_valid,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("wozmon_rom_arbiter: STARVE_LIMIT must be within 1..15");
  end

  logic                  force_dbg;
  logic [1:0]            tag;
  logic [ADDR_WIDTH-1:0] last_addr;

`ifdef ROM_ARB_STARVE_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign force_dbg = (starve_cnt == LIMIT);

  // Counts consecutive denied DBG cycles. Once it reaches the limit DBG is
  // granted on the next cycle it still requests, which clears it, so the
  // hold at LIMIT only matters for the one-cycle window before that grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!dbg_req || dbg_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_dbg = 1'b0;
`endif

  // Reset masks both grants so a request present during reset never reaches
  // the ROM or the response tag.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      cpu_gnt = cpu_req & ~force_dbg;
      dbg_gnt = dbg_req & (~cpu_req | force_dbg);
    end
  end

  // Idle cycles keep the last granted address on the ROM so its address pins
  // do not toggle for nothing.
  always_comb begin
    rom_addr = last_addr;
    if (cpu_gnt) begin
      rom_addr = cpu_addr;
    end else if (dbg_gnt) begin
      rom_addr = dbg_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag       <= 2'b00;
      last_addr <= '0;
    end else begin
      tag <= {dbg_gnt, cpu_gnt};
      if (cpu_gnt || dbg_gnt) begin
        last_addr <= rom_addr;
      end
    end
  end

  // The ROM output register is the only data stage; the tag lines up with it.
  assign cpu_valid = tag[0];
  assign dbg_valid = tag[1];
  assign cpu_data  = rom_dout;
  assign dbg_data  = rom_dout;

endmodule

// File: tb/tb_wozmon_rom_arbiter.sv
module tb_wozmon_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, dbg_req;
  logic [7:0] cpu_addr, dbg_addr;
  logic       cpu_gnt, cpu_valid, dbg_gnt, dbg_valid;
  logic [7:0] cpu_data, dbg_data, rom_addr, rom_dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] rom [256];
  logic       exp_dbg, prev_dbg;

  always #5 clk = ~clk;

  // ROM contents: rom[a] = a ^ 0x5A, except rom[0x1F] = 0xA9.
  //   rom[00]=5A rom[01]=5B rom[02]=58 rom[20]=7A rom[10]=4A rom[FF]=A5
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
    rom[8'h1F] = 8'hA9;
  end

  always_ff @(posedge clk) rom_dout <= rom[rom_addr];

  wozmon_rom_arbiter #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (8),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_addr (cpu_addr),
    .cpu_gnt  (cpu_gnt),
    .cpu_valid(cpu_valid),
    .cpu_data (cpu_data),
    .dbg_req  (dbg_req),
    .dbg_addr (dbg_addr),
    .dbg_gnt  (dbg_gnt),
    .dbg_valid(dbg_valid),
    .dbg_data (dbg_data),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; combinational outputs are checked 1ns
  // later, registered outputs 1ns after the following rising edge.
  task automatic drive(input logic r, input logic cr, input logic [7:0] ca,
                       input logic dr, input logic [7:0] da);
    @(negedge clk);
    rst = r; cpu_req = cr; cpu_addr = ca; dbg_req = dr; dbg_addr = da;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 8'h33; dbg_addr = 8'h44;

    // Reset held two cycles with both requests present
    drive(1, 1, 8'h33, 1, 8'h44);
    chk("rst_cpu_gnt_c0", cpu_gnt, 0);
    chk("rst_dbg_gnt_c0", dbg_gnt, 0);
    tick();
    chk("rst_cpu_valid_c0", cpu_valid, 0);
    chk("rst_dbg_valid_c0", dbg_valid, 0);
    drive(1, 1, 8'h33, 1, 8'h44);
    chk("rst_cpu_gnt_c1", cpu_gnt, 0);
    chk("rst_dbg_gnt_c1", dbg_gnt, 0);
    chk("rst_rom_addr", rom_addr, 8'h00);
    tick();
    drive(0, 0, 8'h33, 0, 8'h44);
    chk("post_rst_cpu_valid", cpu_valid, 0);
    chk("post_rst_dbg_valid", dbg_valid, 0);
    chk("idle_rom_addr", rom_addr, 8'h00);
    chk("idle_cpu_gnt", cpu_gnt, 0);
    tick();
    chk("idle_cpu_valid", cpu_valid, 0);

    // Single CPU read of 0x1F
    drive(0, 1, 8'h1F, 0, 8'h00);
    chk("single_cpu_gnt", cpu_gnt, 1);
    chk("single_dbg_gnt", dbg_gnt, 0);
    chk("single_rom_addr", rom_addr, 8'h1F);
    tick();
    chk("single_cpu_valid", cpu_valid, 1);
    chk("single_cpu_data", cpu_data, 8'hA9);
    chk("single_dbg_valid", dbg_valid, 0);

    // Back-to-back CPU reads 0x00, 0x01, 0x02
    drive(0, 1, 8'h00, 0, 8'h00);
    chk("b2b0_rom_addr", rom_addr, 8'h00);
    tick();
    chk("b2b0_valid", cpu_valid, 1);
    chk("b2b0_data", cpu_data, 8'h5A);
    drive(0, 1, 8'h01, 0, 8'h00);
    tick();
    chk("b2b1_valid", cpu_valid, 1);
    chk("b2b1_data", cpu_data, 8'h5B);
    drive(0, 1, 8'h02, 0, 8'h00);
    tick();
    chk("b2b2_valid", cpu_valid, 1);
    chk("b2b2_data", cpu_data, 8'h58);
    drive(0, 0, 8'h77, 0, 8'h66);
    chk("hold_rom_addr", rom_addr, 8'h02);
    chk("hold_cpu_gnt", cpu_gnt, 0);
    tick();
    chk("hold_cpu_valid", cpu_valid, 0);

    // Address 0xFF then 0x00
    drive(0, 1, 8'hFF, 0, 8'h00);
    tick();
    chk("wrap_ff_data", cpu_data, 8'hA5);
    drive(0, 1, 8'h00, 0, 8'h00);
    tick();
    chk("wrap_00_valid", cpu_valid, 1);
    chk("wrap_00_data", cpu_data, 8'h5A);

    // Contention for 20 cycles, counter starting from 0.
    // With the guard (limit 4): CPU,CPU,CPU,CPU,DBG repeating.
    prev_dbg = 1'b0;
    for (int i = 0; i < 20; i++) begin
`ifdef ROM_ARB_STARVE_EN
      exp_dbg = ((i % 5) == 4);
`else
      exp_dbg = 1'b0;
`endif
      drive(0, 1, 8'h10, 1, 8'h20);
      chk("cont_dbg_gnt", dbg_gnt, exp_dbg);
      chk("cont_cpu_gnt", cpu_gnt, !exp_dbg);
      chk("cont_rom_addr", rom_addr, exp_dbg ? 8'h20 : 8'h10);
      tick();
      chk("cont_dbg_valid", dbg_valid, exp_dbg);
      chk("cont_cpu_valid", cpu_valid, !exp_dbg);
      chk("cont_data", exp_dbg ? dbg_data : cpu_data, exp_dbg ? 8'h7A : 8'h4A);
      prev_dbg = exp_dbg;
    end

    // CPU drops: DBG granted in that same cycle
    drive(0, 0, 8'h10, 1, 8'h20);
    chk("cpu_drop_dbg_gnt", dbg_gnt, 1);
    chk("cpu_drop_rom_addr", rom_addr, 8'h20);
    tick();
    chk("cpu_drop_dbg_valid", dbg_valid, 1);
    chk("cpu_drop_dbg_data", dbg_data, 8'h7A);
    chk("cpu_drop_cpu_valid", cpu_valid, 0);

    // DBG requests for 2 denied cycles, then withdraws
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 8'h10, 1, 8'h20);
      chk("wd_dbg_gnt", dbg_gnt, 0);
      tick();
      chk("wd_dbg_valid", dbg_valid, 0);
    end
    drive(0, 1, 8'h10, 0, 8'h20);
    chk("wd_drop_dbg_gnt", dbg_gnt, 0);
    tick();
    chk("wd_drop_dbg_valid", dbg_valid, 0);

    // Counter must be back at 0: DBG again waits four cycles under contention
    for (int i = 0; i < 5; i++) begin
`ifdef ROM_ARB_STARVE_EN
      exp_dbg = (i == 4);
`else
      exp_dbg = 1'b0;
`endif
      drive(0, 1, 8'h10, 1, 8'h20);
      chk("wd_cont_dbg_gnt", dbg_gnt, exp_dbg);
      tick();
      chk("wd_cont_dbg_valid", dbg_valid, exp_dbg);
    end

    // Reset asserted with a CPU request pending
    drive(1, 1, 8'h05, 0, 8'h00);
    chk("midrst_cpu_gnt", cpu_gnt, 0);
    chk("midrst_dbg_gnt", dbg_gnt, 0);
    tick();
    chk("midrst_cpu_valid", cpu_valid, 0);
    chk("midrst_dbg_valid", dbg_valid, 0);
    drive(0, 0, 8'h05, 0, 8'h00);
    chk("midrst_rom_addr", rom_addr, 8'h00);
    tick();
    chk("midrst_cpu_valid2", cpu_valid, 0);

    // Re-request after reset works normally
    drive(0, 1, 8'h1F, 0, 8'h00);
    chk("rereq_cpu_gnt", cpu_gnt, 1);
    tick();
    chk("rereq_cpu_valid", cpu_valid, 1);
    chk("rereq_cpu_data", cpu_data, 8'hA9);
    drive(0, 0, 8'h00, 0, 8'h00);
    tick();
    chk("rereq_cpu_valid_end", cpu_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
